// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register offsets, status bit indices and FSM state types for uart_mmio
package uart_mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with push/pop, full/empty flags and occupancy count
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define FIFO state.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped 8N1 UART: 4-byte register window, TX FIFO and serialiser
// RX path (synchroniser, RX FSM, holding register) is built only when UART_MMIO_RX_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          CLK_DIV   = 434,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        sel,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam int            FAW      = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BAUD_TOP = CW'(CLK_DIV - 1);

  logic [1:0]   offset;
  logic         wr_data;
  logic         wr_status;
  logic         fifo_pop;
  logic [7:0]   fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic [FAW:0] fifo_count;
  logic [7:0]   status;

  tx_state_t     tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic [2:0]    tx_bit, tx_bit_d;

  assign sel       = (cpu_address[15:2] == BASE_ADDR[15:2]);
  assign offset    = cpu_address[1:0];
  assign wr_data   = sel && cpu_write && (offset == REG_DATA);
  assign wr_status = sel && cpu_write && (offset == REG_STATUS);

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_data),
    .push_data (cpu_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_shift <= tx_shift_d;
      tx_bit   <= tx_bit_d;
    end
  end

  // STOP reloads straight into START when more bytes wait, so frames abut.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_shift_d = tx_shift;
    tx_bit_d   = tx_bit;
    fifo_pop   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = BAUD_TOP;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_d   = BAUD_TOP;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d   = BAUD_TOP;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_bit_d   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt - CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_cnt_d   = BAUD_TOP;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_txd = (tx_state == TX_START) ? 1'b0 :
                    (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

`ifdef UART_MMIO_RX_EN
  localparam logic [CW-1:0] HALF_TOP = CW'(CLK_DIV / 2 - 1);

  logic          rx_s1, rx_s2, rx_q;
  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic          rx_done;
  logic          rx_new;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_overrun, frame_err;
  logic          clr_valid, clr_overrun, clr_frame;

  assign clr_valid   = wr_status && cpu_wdata[ST_RX_VALID];
  assign clr_overrun = wr_status && cpu_wdata[ST_RX_OVERRUN];
  assign clr_frame   = wr_status && cpu_wdata[ST_FRAME_ERR];
  assign rx_new      = rx_done && rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_q     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_q     <= rx_s2;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_shift <= rx_shift_d;
      rx_bit   <= rx_bit_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_shift_d = rx_shift;
    rx_bit_d   = rx_bit;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_q && !rx_s2) begin
          rx_cnt_d   = HALF_TOP;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_s2) begin
            rx_cnt_d   = BAUD_TOP;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_d   = BAUD_TOP;
          rx_shift_d = {rx_s2, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte arriving on the same edge as a pop counts as fresh, not as an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_new) rx_data <= rx_shift;
      if (rx_new)         rx_valid <= 1'b1;
      else if (clr_valid) rx_valid <= 1'b0;
      if (rx_new && rx_valid && !clr_valid) rx_overrun <= 1'b1;
      else if (clr_overrun)                 rx_overrun <= 1'b0;
      if (rx_done && !rx_s2) frame_err <= 1'b1;
      else if (clr_frame)    frame_err <= 1'b0;
    end
  end
`else
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, frame_err;
  logic       unused_rx;

  assign rx_data    = '0;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
  assign unused_rx  = uart_rxd ^ wr_status;
`endif

  logic unused_count;
  assign unused_count = ^fifo_count;

  always_comb begin
    status                = '0;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = fifo_empty && (tx_state == TX_IDLE);
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    cpu_rdata = '0;
    if (sel) begin
      case (offset)
        REG_DATA:   cpu_rdata = rx_data;
        REG_STATUS: cpu_rdata = status;
        default:    cpu_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - directed self-checking bench for uart_mmio (CLK_DIV=4, TX_DEPTH=4)
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        sel;
  logic        uart_txd;
  logic        uart_rxd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_mmio #(.BASE_ADDR(16'hFF00), .CLK_DIV(4), .TX_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .sel         (sel),
    .uart_txd    (uart_txd),
    .uart_rxd    (uart_rxd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_write   = 1'b1;
    cpu_address = a;
    cpu_wdata   = d;
    @(negedge clk);
    cpu_write   = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    cpu_address = a;
    #1;
    d = cpu_rdata;
  endtask

  // Offset 0 is the first negedge with txd low; bit k is sampled at offset 4k+2.
  task automatic tx_frame(input bit search, input logic [7:0] exp, input string tag,
                          output int waited);
    logic [7:0] d;
    waited = 0;
    if (search) begin
      while (uart_txd !== 1'b0 && waited < 300) begin
        @(negedge clk);
        waited++;
      end
    end
    check({tag, "_start_edge"}, uart_txd, 1'b0);
    repeat (2) @(negedge clk);
    check({tag, "_start_bit"}, uart_txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      d[i] = uart_txd;
    end
    check({tag, "_data"}, d, exp);
    repeat (4) @(negedge clk);
    check({tag, "_stop_bit"}, uart_txd, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    int         w;
    logic       stayed_high;

    rst = 1'b0; cpu_write = 1'b0; cpu_address = 16'h1234; cpu_wdata = 8'h00; uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_sel_1234", sel, 1'b0);
    check("rst_rdata_unsel", cpu_rdata, 8'h00);
    bus_rd(16'hFF01, rd); check("rst_status", rd, 8'h04);
    check("sel_ff01", sel, 1'b1);
    bus_rd(16'hFF02, rd); check("rst_off2", rd, 8'h00);
    bus_rd(16'hFF03, rd); check("rst_off3", rd, 8'h00);
    bus_rd(16'hFF00, rd); check("rst_data", rd, 8'h00);
    bus_rd(16'hFF04, rd); check("sel_ff04", sel, 1'b0);
    bus_rd(16'hFEFF, rd); check("sel_feff", sel, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    bus_wr(16'hFF00, 8'hA5);
    check("tx_latency_pre", uart_txd, 1'b1);
    tx_frame(1'b1, 8'hA5, "tx_a5", w);
    check("tx_latency", w, 1);
    bus_rd(16'hFF01, rd); check("tx_done_status", rd, 8'h04);
    @(negedge clk);

    bus_wr(16'hFF02, 8'h55);
    bus_rd(16'hFF01, rd); check("off2_write_ignored", rd, 8'h04);
    @(negedge clk);

    fork
      begin
        bus_wr(16'hFF00, 8'h01);
        bus_wr(16'hFF00, 8'h02);
        bus_wr(16'hFF00, 8'h03);
        bus_wr(16'hFF00, 8'h04);
        bus_wr(16'hFF00, 8'h05);
        bus_rd(16'hFF01, rd); check("fifo_full_5th", rd, 8'h02);
        bus_wr(16'hFF00, 8'h06);
        bus_rd(16'hFF01, rd); check("fifo_full_6th", rd, 8'h02);
      end
      begin
        int wb;
        tx_frame(1'b1, 8'h01, "burst_01", wb);
        tx_frame(1'b0, 8'h02, "burst_02", wb);
        tx_frame(1'b0, 8'h03, "burst_03", wb);
        tx_frame(1'b0, 8'h04, "burst_04", wb);
        tx_frame(1'b0, 8'h05, "burst_05", wb);
      end
    join
    bus_rd(16'hFF01, rd); check("burst_drained", rd, 8'h04);
    stayed_high = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) stayed_high = 1'b0;
    end
    check("byte6_dropped", stayed_high, 1'b1);

`ifdef UART_MMIO_RX_EN
    uart_send(8'h3C, 1'b1);
    bus_rd(16'hFF01, rd); check("rx_3c_status", rd, 8'h05);
    bus_rd(16'hFF00, rd); check("rx_3c_data", rd, 8'h3C);
    bus_wr(16'hFF01, 8'h01);
    bus_rd(16'hFF01, rd); check("rx_pop", rd, 8'h04);

    uart_send(8'h11, 1'b1);
    uart_send(8'h22, 1'b1);
    bus_rd(16'hFF00, rd); check("rx_overrun_data", rd, 8'h22);
    bus_rd(16'hFF01, rd); check("rx_overrun_bits", rd & 8'h19, 8'h09);
    bus_wr(16'hFF01, 8'h08);
    bus_rd(16'hFF01, rd); check("rx_overrun_clr", rd & 8'h19, 8'h01);

    uart_send(8'h55, 1'b0);
    bus_rd(16'hFF01, rd); check("rx_frame_err", rd & 8'h19, 8'h11);
    bus_rd(16'hFF00, rd); check("rx_frame_err_data", rd, 8'h22);
    bus_wr(16'hFF01, 8'h10);
    bus_rd(16'hFF01, rd); check("rx_frame_err_clr", rd & 8'h19, 8'h01);

    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (60) @(negedge clk);
    bus_rd(16'hFF01, rd); check("rx_glitch_status", rd, 8'h05);
    bus_rd(16'hFF00, rd); check("rx_glitch_data", rd, 8'h22);

    bus_wr(16'hFF01, 8'h01);
    uart_send(8'h81, 1'b1);
    bus_rd(16'hFF01, rd); check("rx_81_status", rd, 8'h05);
    bus_rd(16'hFF00, rd); check("rx_81_data", rd, 8'h81);
    bus_wr(16'hFF01, 8'h01);
`else
    uart_send(8'h3C, 1'b1);
    bus_rd(16'hFF01, rd); check("norx_status", rd, 8'h04);
    bus_rd(16'hFF00, rd); check("norx_data", rd, 8'h00);
    bus_wr(16'hFF01, 8'h19);
    bus_rd(16'hFF01, rd); check("norx_clr_ignored", rd, 8'h04);
`endif

    @(negedge clk);
    bus_wr(16'hFF00, 8'h00);
    bus_wr(16'hFF00, 8'h00);
    repeat (12) @(negedge clk);
    check("mid_frame_low", uart_txd, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_async_txd", uart_txd, 1'b1);
    bus_rd(16'hFF01, rd); check("rst_mid_status", rd, 8'h04);
    @(negedge clk);
    rst = 1'b1;
    stayed_high = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) stayed_high = 1'b0;
    end
    check("rst_fifo_flushed", stayed_high, 1'b1);
    bus_rd(16'hFF01, rd); check("post_rst_status", rd, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
